// File: rtl/mem_stage_hs.sv
// MEM pipeline stage: EXE/WB valid-allow_in handshake, outstanding data-SRAM response tracking,
// load alignment/extension and bypass outputs. Define MEM_FWD_EN to forward completed load data.
module mem_stage_hs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              exe_ready_go,
  output logic              allow_in,
  input  logic [PC_W-1:0]   exe_inst,
  input  logic [PC_W-1:0]   exe_pc,
  input  logic              exe_rf_we,
  input  logic [RA_W-1:0]   exe_dest,
  input  logic [DATA_W-1:0] exe_result,
  input  logic              exe_mem_req,
  input  logic              exe_mem_ld,
  input  logic [2:0]        exe_ld_op,
  input  logic              data_sram_data_ok,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              ready_go,
  input  logic              wb_allow_in,
  output logic              valid,
  output logic [PC_W-1:0]   mem_inst,
  output logic [PC_W-1:0]   mem_pc,
  output logic              mem_rf_we,
  output logic [RA_W-1:0]   mem_dest,
  output logic [DATA_W-1:0] mem_result,
  output logic [DATA_W-1:0] fwd_data,
  output logic              fwd_stall
);

  localparam int unsigned OffW = (DATA_W == 64) ? 3 : 2;

  localparam logic [2:0] OpLb  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLw  = 3'b010;
  localparam logic [2:0] OpLd  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpLhu = 3'b101;
  localparam logic [2:0] OpLwu = 3'b110;

  typedef enum logic [1:0] {StEmpty, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [1:0]        discard_q, discard_d;
  logic [2:0]        discard_sum;

  logic [PC_W-1:0]   inst_q;
  logic [PC_W-1:0]   pc_q;
  logic              rf_we_q;
  logic [RA_W-1:0]   dest_q;
  logic [DATA_W-1:0] result_q;
  logic              mem_ld_q;
  logic [2:0]        ld_op_q;
  logic [DATA_W-1:0] rbuf_q;

  logic              counted_ok;
  logic              wait_hit;
  logic              accept;
  logic              retire;
  logic [OffW-1:0]   off;
  logic [DATA_W-1:0] ld_raw;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] ld_ext;

  // Responses still owed to flushed requests are swallowed before any are counted.
  assign counted_ok = data_sram_data_ok & (discard_q == 2'd0);
  assign wait_hit   = (state_q == StWait) & counted_ok;
  assign ready_go   = (state_q == StDone) | wait_hit;
  assign allow_in   = ~valid_q | (ready_go & wb_allow_in);
  assign accept     = exe_ready_go & allow_in & ~flush;
  assign retire     = ready_go & wb_allow_in;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = StEmpty;
      valid_d = 1'b0;
    end else if (accept) begin
      state_d = exe_mem_req ? StWait : StDone;
      valid_d = 1'b1;
    end else if (retire) begin
      state_d = StEmpty;
      valid_d = 1'b0;
    end else if (wait_hit) begin
      state_d = StDone;
    end
  end

  // A dropped response and a flush-induced increment in the same cycle cancel out.
  always_comb begin
    discard_sum = {1'b0, discard_q};
    if (flush && (state_q == StWait) && !counted_ok) begin
      discard_sum = discard_sum + 3'd1;
    end
    if (flush && exe_ready_go && exe_mem_req) begin
      discard_sum = discard_sum + 3'd1;
    end
    if (data_sram_data_ok && (discard_q != 2'd0)) begin
      discard_sum = discard_sum - 3'd1;
    end
    discard_d = (discard_sum > 3'd3) ? 2'd3 : discard_sum[1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StEmpty;
      valid_q   <= 1'b0;
      discard_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q   <= '0;
      pc_q     <= '0;
      rf_we_q  <= 1'b0;
      dest_q   <= '0;
      result_q <= '0;
      mem_ld_q <= 1'b0;
      ld_op_q  <= 3'b000;
    end else if (accept) begin
      inst_q   <= exe_inst;
      pc_q     <= exe_pc;
      rf_we_q  <= exe_rf_we;
      dest_q   <= exe_dest;
      result_q <= exe_result;
      mem_ld_q <= exe_mem_ld;
      ld_op_q  <= exe_ld_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rbuf_q <= '0;
    end else if (wait_hit && !flush) begin
      rbuf_q <= data_sram_rdata;
    end
  end

  // In DONE the response comes from the buffer; in WAIT it bypasses straight from the SRAM.
  assign ld_raw  = (state_q == StDone) ? rbuf_q : data_sram_rdata;
  assign off     = result_q[OffW-1:0];
  assign shifted = ld_raw >> {off, 3'b000};

  always_comb begin
    ld_ext = DATA_W'($signed(shifted[31:0]));
    case (ld_op_q)
      OpLb:    ld_ext = DATA_W'($signed(shifted[7:0]));
      OpLh:    ld_ext = DATA_W'($signed(shifted[15:0]));
      OpLw:    ld_ext = DATA_W'($signed(shifted[31:0]));
      OpLd:    ld_ext = (DATA_W == 64) ? shifted : DATA_W'($signed(shifted[31:0]));
      OpLbu:   ld_ext = DATA_W'(shifted[7:0]);
      OpLhu:   ld_ext = DATA_W'(shifted[15:0]);
      OpLwu:   ld_ext = DATA_W'(shifted[31:0]);
      default: ld_ext = DATA_W'($signed(shifted[31:0]));
    endcase
  end

  assign valid      = valid_q;
  assign mem_inst   = inst_q;
  assign mem_pc     = pc_q;
  assign mem_rf_we  = valid_q & rf_we_q;
  assign mem_dest   = dest_q;
  assign mem_result = mem_ld_q ? ld_ext : result_q;
  assign fwd_stall  = valid_q & (state_q == StWait) & mem_ld_q & ~counted_ok;

`ifdef MEM_FWD_EN
  // Meaningful only while ready_go is high.
  assign fwd_data = mem_result;
`else
  assign fwd_data = result_q;
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: 32-bit and 64-bit instances, directed stimulus,
// retire-time monitors compare against queued expectations.
module tb_mem_stage_hs;

  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] res;
  } exp_t;

  logic clk;
  logic reset;

  logic        flush, exe_ready_go, allow_in, exe_rf_we, exe_mem_req, exe_mem_ld;
  logic [31:0] exe_inst, exe_pc, exe_result, data_sram_rdata;
  logic [4:0]  exe_dest, mem_dest;
  logic [2:0]  exe_ld_op;
  logic        data_sram_data_ok, ready_go, wb_allow_in, valid, mem_rf_we, fwd_stall;
  logic [31:0] mem_inst, mem_pc, mem_result, fwd_data;

  logic        flush64, rg64, allow_in64, rf_we64, mreq64, ld64;
  logic [31:0] inst64, pc64, mem_inst64, mem_pc64;
  logic [63:0] result64, rdata64, mem_result64, fwd_data64;
  logic [4:0]  dest64, mem_dest64;
  logic [2:0]  op64;
  logic        ok64, ready_go64, wb64, valid64, mem_rf_we64, fwd_stall64;

  exp_t q32[$];
  exp_t q64[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_stage_hs #(.DATA_W(32), .PC_W(32), .RA_W(5)) u_dut32 (
    .clk(clk), .reset(reset), .flush(flush), .exe_ready_go(exe_ready_go), .allow_in(allow_in),
    .exe_inst(exe_inst), .exe_pc(exe_pc), .exe_rf_we(exe_rf_we), .exe_dest(exe_dest),
    .exe_result(exe_result), .exe_mem_req(exe_mem_req), .exe_mem_ld(exe_mem_ld),
    .exe_ld_op(exe_ld_op), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ready_go(ready_go), .wb_allow_in(wb_allow_in),
    .valid(valid), .mem_inst(mem_inst), .mem_pc(mem_pc), .mem_rf_we(mem_rf_we),
    .mem_dest(mem_dest), .mem_result(mem_result), .fwd_data(fwd_data), .fwd_stall(fwd_stall)
  );

  mem_stage_hs #(.DATA_W(64), .PC_W(32), .RA_W(5)) u_dut64 (
    .clk(clk), .reset(reset), .flush(flush64), .exe_ready_go(rg64), .allow_in(allow_in64),
    .exe_inst(inst64), .exe_pc(pc64), .exe_rf_we(rf_we64), .exe_dest(dest64),
    .exe_result(result64), .exe_mem_req(mreq64), .exe_mem_ld(ld64), .exe_ld_op(op64),
    .data_sram_data_ok(ok64), .data_sram_rdata(rdata64), .ready_go(ready_go64),
    .wb_allow_in(wb64), .valid(valid64), .mem_inst(mem_inst64), .mem_pc(mem_pc64),
    .mem_rf_we(mem_rf_we64), .mem_dest(mem_dest64), .mem_result(mem_result64),
    .fwd_data(fwd_data64), .fwd_stall(fwd_stall64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string name, input logic act, input logic expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, expv);
    end
  endtask

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Monitors: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin : mon32
    exp_t e;
    if (!reset && valid && ready_go && wb_allow_in) begin
      if (q32.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon32_unexpected: got retire pc 0x%0h, expected none", mem_pc);
      end else begin
        e = q32.pop_front();
        chkv("mon32_pc", 64'(mem_pc), 64'(e.pc));
        chkv("mon32_result", 64'(mem_result), e.res);
      end
    end
  end

  always @(negedge clk) begin : mon64
    exp_t e;
    if (!reset && valid64 && ready_go64 && wb64) begin
      if (q64.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL mon64_unexpected: got retire pc 0x%0h, expected none", mem_pc64);
      end else begin
        e = q64.pop_front();
        chkv("mon64_pc", 64'(mem_pc64), 64'(e.pc));
        chkv("mon64_result", mem_result64, e.res);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle32();
    exe_ready_go      = 1'b0;
    exe_mem_req       = 1'b0;
    exe_mem_ld        = 1'b0;
    data_sram_data_ok = 1'b0;
    flush             = 1'b0;
  endtask

  task automatic issue32(input logic [31:0] pc, input logic [31:0] res, input logic mreq,
                         input logic ld, input logic [2:0] op);
    exe_ready_go = 1'b1;
    exe_pc       = pc;
    exe_inst     = pc ^ 32'hA5A5_0000;
    exe_result   = res;
    exe_rf_we    = 1'b1;
    exe_dest     = pc[6:2];
    exe_mem_req  = mreq;
    exe_mem_ld   = ld;
    exe_ld_op    = op;
  endtask

  task automatic push32(input logic [31:0] pc, input logic [31:0] v);
    exp_t t;
    t.pc  = pc;
    t.res = 64'(v);
    q32.push_back(t);
  endtask

  task automatic load32(input logic [31:0] pc, input logic [31:0] addr, input logic [2:0] op,
                        input logic [31:0] rd, input logic [31:0] expv, input int stall);
    issue32(pc, addr, 1'b1, 1'b1, op);
    push32(pc, expv);
    step();
    idle32();
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk1("ld_wait_stall", fwd_stall, 1'b1);
      chk1("ld_wait_not_ready", ready_go, 1'b0);
      step();
    end
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = rd;
    @(negedge clk);
    chk1("ld_dataok_ready", ready_go, 1'b1);
    chk1("ld_dataok_no_stall", fwd_stall, 1'b0);
    step();
    data_sram_data_ok = 1'b0;
  endtask

  task automatic load64(input logic [31:0] pc, input logic [63:0] addr, input logic [2:0] op,
                        input logic [63:0] expv);
    exp_t t;
    rg64     = 1'b1;
    pc64     = pc;
    inst64   = ~pc;
    result64 = addr;
    mreq64   = 1'b1;
    ld64     = 1'b1;
    op64     = op;
    t.pc     = pc;
    t.res    = expv;
    q64.push_back(t);
    step();
    rg64    = 1'b0;
    ok64    = 1'b1;
    rdata64 = 64'h89AB_CDEF_0123_4567;
    @(negedge clk);
    chk1("ld64_ready", ready_go64, 1'b1);
    step();
    ok64 = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle32();
    exe_inst = '0; exe_pc = '0; exe_rf_we = 1'b0; exe_dest = '0; exe_result = '0;
    exe_ld_op = 3'b000; data_sram_rdata = '0; wb_allow_in = 1'b1;
    flush64 = 1'b0; rg64 = 1'b0; rf_we64 = 1'b1; mreq64 = 1'b0; ld64 = 1'b0; op64 = 3'b000;
    inst64 = '0; pc64 = '0; result64 = '0; rdata64 = '0; dest64 = 5'd3; ok64 = 1'b0;
    wb64 = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_valid", valid, 1'b0);
    chk1("rst_ready_go", ready_go, 1'b0);
    chk1("rst_allow_in", allow_in, 1'b1);
    chk1("rst_rf_we", mem_rf_we, 1'b0);
    chk1("rst_fwd_stall", fwd_stall, 1'b0);
    chk1("rst_valid64", valid64, 1'b0);
    step();
    reset = 1'b0;

    // Back-to-back ALU ops.
    issue32(32'h100, 32'h1234, 1'b0, 1'b0, 3'b000);
    push32(32'h100, 32'h1234);
    @(negedge clk);
    chk1("alu_allow_in_empty", allow_in, 1'b1);
    step();
    issue32(32'h104, 32'h5678, 1'b0, 1'b0, 3'b000);
    push32(32'h104, 32'h5678);
    @(negedge clk);
    chk1("alu_valid", valid, 1'b1);
    chk1("alu_ready_go", ready_go, 1'b1);
    chk1("alu_allow_in_b2b", allow_in, 1'b1);
    chk1("alu_rf_we", mem_rf_we, 1'b1);
    chkv("alu_fwd_data", 64'(fwd_data), 64'h1234);
    step();
    idle32();
    step();

    // Sign/zero-extended sub-word loads and LD on a 32-bit datapath.
    load32(32'h200, 32'h1003, 3'b000, 32'h80FF_FFFF, 32'hFFFF_FF80, 2);
    load32(32'h204, 32'h1003, 3'b100, 32'h80FF_FFFF, 32'h0000_0080, 2);
    load32(32'h208, 32'h1000, 3'b001, 32'h1234_8001, 32'hFFFF_8001, 0);
    load32(32'h20C, 32'h1000, 3'b011, 32'h1234_5678, 32'h1234_5678, 1);

    // LHU held by WB backpressure: response must be buffered.
    issue32(32'h210, 32'h2002, 1'b1, 1'b1, 3'b101);
    push32(32'h210, 32'h0000_BEEF);
    step();
    idle32();
    @(negedge clk);
    chk1("lhu_stall", fwd_stall, 1'b1);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_0000;
    wb_allow_in       = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("lhu_hold_ready", ready_go, 1'b1);
      chk1("lhu_hold_allow_in", allow_in, 1'b0);
      chkv("lhu_hold_result", 64'(mem_result), 64'h0000_BEEF);
      step();
      data_sram_data_ok = 1'b0;
      data_sram_rdata   = 32'h1234_5678;
    end
    wb_allow_in = 1'b1;
    @(negedge clk);
    chk1("lhu_release_allow_in", allow_in, 1'b1);
    step();

    // Flush in WAIT: the stale response is dropped.
    issue32(32'h300, 32'h3000, 1'b1, 1'b1, 3'b010);
    step();
    idle32();
    flush = 1'b1;
    @(negedge clk);
    chk1("flush_pre_allow_in", allow_in, 1'b0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk1("flush_valid", valid, 1'b0);
    chk1("flush_allow_in", allow_in, 1'b1);
    step();
    issue32(32'h304, 32'h3004, 1'b1, 1'b1, 3'b010);
    push32(32'h304, 32'h0000_CAFE);
    step();
    idle32();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_DEAD;
    @(negedge clk);
    chk1("drop_not_ready", ready_go, 1'b0);
    chk1("drop_stall", fwd_stall, 1'b1);
    step();
    data_sram_rdata = 32'h0000_CAFE;
    @(negedge clk);
    chk1("after_drop_ready", ready_go, 1'b1);
    step();
    data_sram_data_ok = 1'b0;

    // Flush in WAIT while EXE's accepted request is also cancelled: two responses owed.
    issue32(32'h310, 32'h3100, 1'b1, 1'b1, 3'b010);
    step();
    idle32();
    flush        = 1'b1;
    exe_ready_go = 1'b1;
    exe_mem_req  = 1'b1;
    step();
    idle32();
    step();
    issue32(32'h314, 32'h3140, 1'b1, 1'b1, 3'b010);
    push32(32'h314, 32'h0000_0077);
    step();
    idle32();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_0011;
    @(negedge clk);
    chk1("dbl_drop1", ready_go, 1'b0);
    step();
    data_sram_rdata = 32'h0000_0022;
    @(negedge clk);
    chk1("dbl_drop2", ready_go, 1'b0);
    step();
    data_sram_rdata = 32'h0000_0077;
    @(negedge clk);
    chk1("dbl_counted", ready_go, 1'b1);
    step();
    data_sram_data_ok = 1'b0;

    // Async reset mid-WAIT with a discard pending clears everything.
    issue32(32'h320, 32'h3200, 1'b1, 1'b1, 3'b010);
    step();
    idle32();
    flush = 1'b1;
    step();
    flush = 1'b0;
    issue32(32'h324, 32'h3240, 1'b1, 1'b1, 3'b010);
    step();
    idle32();
    @(negedge clk);
    chk1("pre_rst_valid", valid, 1'b1);
    step();
    #2;
    reset = 1'b1;
    #1;
    chk1("async_rst_valid", valid, 1'b0);
    chk1("async_rst_allow_in", allow_in, 1'b1);
    chk1("async_rst_stall", fwd_stall, 1'b0);
    step();
    reset = 1'b0;
    issue32(32'h328, 32'h0000, 1'b1, 1'b1, 3'b010);
    push32(32'h328, 32'h0000_5555);
    step();
    idle32();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_5555;
    @(negedge clk);
    chk1("post_rst_counted", ready_go, 1'b1);
    step();
    data_sram_data_ok = 1'b0;

    // 64-bit datapath.
    load64(32'h500, 64'h1004, 3'b110, 64'h0000_0000_89AB_CDEF);
    load64(32'h504, 64'h1004, 3'b010, 64'hFFFF_FFFF_89AB_CDEF);
    load64(32'h508, 64'h1000, 3'b011, 64'h89AB_CDEF_0123_4567);
    load64(32'h50C, 64'h1007, 3'b000, 64'hFFFF_FFFF_FFFF_FF89);

    repeat (2) step();
    chkv("q32_drained", 64'(q32.size()), 64'd0);
    chkv("q64_drained", 64'(q64.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
Parametrised MEM pipeline stage with a valid/allow_in handshake to EXE and WB. It also tracks an outstanding data-SRAM transaction issued in EXE. It waits for that transaction's data_ok, buffers the response, and aligns and extends load data by op and byte offset. It supports flush with discard of stale responses, and drives WB and the bypass network.

Parameters:
DATA_W, 32, datapath/SRAM data width; legal values 32 or 64.
PC_W, 32, PC and instruction width.
RA_W, 5, register-file address width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  cancel the held instruction and any outstanding response
exe_ready_go  in  1  EXE has a valid instruction to hand over
allow_in  out  1  stage can accept from EXE this cycle
exe_inst  in  PC_W  instruction
exe_pc  in  PC_W  PC
exe_rf_we  in  1  register write enable
exe_dest  in  RA_W  destination register
exe_result  in  DATA_W  ALU result or memory address
exe_mem_req  in  1  SRAM request was accepted (addr_ok) in EXE
exe_mem_ld  in  1  the request is a load
exe_ld_op  in  3  000 LB, 001 LH, 010 LW, 011 LD (DATA_W=64 only), 100 LBU, 101 LHU, 110 LWU
data_sram_data_ok  in  1  response valid, in request order
data_sram_rdata  in  DATA_W  response data
ready_go  out  1  stage holds a finished instruction
wb_allow_in  in  1  WB accepts
valid  out  1  stage holds an instruction
mem_inst  out  PC_W  held instruction
mem_pc  out  PC_W  held PC
mem_rf_we  out  1  valid & rf_we
mem_dest  out  RA_W  destination register
mem_result  out  DATA_W  final write-back value
fwd_data  out  DATA_W  bypass value (see optional feature)
fwd_stall  out  1  held load is still waiting for data

Behaviour:
- Reset (async): valid=0, state=EMPTY, discard_cnt=0, all payload registers 0; therefore ready_go=0, allow_in=1, mem_rf_we=0, fwd_stall=0.
- allow_in = ~valid | (ready_go & wb_allow_in).
- Accept when exe_ready_go & allow_in & ~flush: capture all exe_* fields and set valid=1.
- Retire when ready_go & wb_allow_in with no simultaneous accept: valid=0.
- FSM:
  - EMPTY: on accept, go to WAIT if exe_mem_req, otherwise DONE.
  - WAIT: on a counted data_ok, capture rdata into rbuf and go to DONE.
  - DONE: on retire with no accept, go to EMPTY; on retire plus accept, follow the EMPTY accept rules.
- A data_ok is "counted" only when discard_cnt==0. A data_ok with discard_cnt>0 is dropped and decrements the counter.
- ready_go is asserted in DONE, or in WAIT on a counted data_ok in the same cycle (zero-bubble). In the zero-bubble case the response goes straight to mem_result.
- Load result:
  - off = result[1:0] for DATA_W=32, result[2:0] for DATA_W=64.
  - Byte/half/word are selected at offset off×8, then sign- or zero-extended to DATA_W.
  - LW on 32-bit returns the full word. LD returns the full word and is treated as LW when DATA_W=32.
  - Misaligned offsets are not checked; lower bits are used as-is.
- mem_result = exe_mem_ld ? extended load : exe_result. Stores return exe_result.
- fwd_stall = valid & state==WAIT & exe_mem_ld & ~counted data_ok.
- flush, highest priority:
  - valid=0, state=EMPTY, no accept that cycle.
  - If state==WAIT and no counted data_ok this cycle, discard_cnt increments.
  - If exe_ready_go & exe_mem_req is also present (EXE request being cancelled), discard_cnt increments again. Saturates at 3.
- A simultaneous dropped data_ok and flush increment net out on discard_cnt.
- After flush, a new instruction with mem_req enters WAIT and ignores responses until discard_cnt reaches 0.

Optional Feature:
MEM_FWD_EN.
- Defined: fwd_data = mem_result, valid only when ready_go (captured data or zero-bubble data_ok).
- Undefined: fwd_data = exe_result register (ALU forwarding only); loads are always reported through fwd_stall.

Test Plan:
- ALU op, wb_allow_in=1: exe_result=0x1234 in cycle 0 -> valid, ready_go and mem_result=0x1234 in cycle 1; allow_in stays 1 for back-to-back instructions.
- LB at off=3, data_ok two cycles after accept, rdata=0x80FF_FF_FF -> mem_result=0xFFFF_FF80, fwd_stall=1 for two cycles, ready_go on the data_ok cycle; repeat with LBU -> 0x0000_0080.
- LHU off=2, data_ok with wb_allow_in=0 for 3 cycles, rdata=0xBEEF_0000 -> mem_result holds 0x0000_BEEF, allow_in=0 until retire.
- Flush while in WAIT, then a new LW enters -> first data_ok (0xDEAD) dropped, second data_ok (0xCAFE) gives mem_result=0xCAFE.
- Assert reset asynchronously mid-WAIT -> valid=0 and allow_in=1 immediately (before the next edge), discard_cnt=0.
- DATA_W=64, LWU off=4, rdata=0x89ABCDEF_01234567 -> mem_result=0x00000000_89ABCDEF; LW -> 0xFFFFFFFF_89ABCDEF.
